// File: rtl/round_controller.sv
// Match-level sequencer: IDLE -> INTRO -> FIGHT -> KO -> (INTRO | MATCH_OVER), driving the health block reset and attack gating.
// Optional round timer is built only when ROUND_TIMER_EN is defined; otherwise timer reads 0 and rounds end only on KO.
module round_controller #(
    parameter int unsigned TICK_DIV      = 100_000_000,
    parameter int unsigned ROUND_TIME    = 99,
    parameter int unsigned INTRO_TICKS   = 3,
    parameter int unsigned KO_HOLD_TICKS = 2,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned MAX_ROUNDS    = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [8:0] health_1,
    input  logic [8:0] health_2,
    output logic       hm_reset,
    output logic       fight_en,
    output logic [2:0] phase,
    output logic [2:0] round_num,
    output logic [6:0] timer,
    output logic [1:0] wins_1,
    output logic [1:0] wins_2,
    output logic [1:0] round_winner,
    output logic [1:0] match_winner,
    output logic       round_done
);

    localparam int unsigned TCW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_MAX = (INTRO_TICKS > KO_HOLD_TICKS) ? INTRO_TICKS : KO_HOLD_TICKS;
    localparam int unsigned PCW     = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int unsigned TMW     = 7;
    localparam int unsigned WW      = 2;
    localparam int unsigned RW      = 3;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INTRO = 3'd1,
        ST_FIGHT = 3'd2,
        ST_KO    = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [TCW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [PCW-1:0]  pcnt_q, pcnt_d;
    logic [RW-1:0]   round_q, round_d;
    logic [WW-1:0]   wins1_q, wins1_d;
    logic [WW-1:0]   wins2_q, wins2_d;
    logic [1:0]      rwin_q, rwin_d;
    logic [1:0]      mwin_q, mwin_d;
    logic            hm_reset_q, hm_reset_d;
    logic            fight_en_q, fight_en_d;
    logic            round_done_q, round_done_d;
    logic            tick;
    logic            timeout;
    logic            ko_hit;
    logic [1:0]      ko_win;
    logic            enter_intro;

`ifdef ROUND_TIMER_EN
    logic [TMW-1:0]  timer_q, timer_d;
    assign timeout = (timer_q == '0);
    assign timer   = timer_q;
`else
    logic            unused_round_time;
    assign unused_round_time = ^TMW'(ROUND_TIME);
    assign timeout = 1'b0;
    assign timer   = '0;
`endif

    assign tick = (tick_cnt_q == TCW'(TICK_DIV - 1));

    // Round outcome: double KO, single KO, then timeout decided on remaining health.
    always_comb begin
        ko_hit = 1'b1;
        ko_win = WIN_NONE;
        if (health_1 == '0 && health_2 == '0) begin
            ko_win = WIN_DRAW;
        end else if (health_2 == '0) begin
            ko_win = WIN_P1;
        end else if (health_1 == '0) begin
            ko_win = WIN_P2;
        end else if (timeout) begin
            if (health_1 > health_2) begin
                ko_win = WIN_P1;
            end else if (health_2 > health_1) begin
                ko_win = WIN_P2;
            end else begin
                ko_win = WIN_DRAW;
            end
        end else begin
            ko_hit = 1'b0;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        round_d      = round_q;
        wins1_d      = wins1_q;
        wins2_d      = wins2_q;
        rwin_d       = rwin_q;
        mwin_d       = mwin_q;
        round_done_d = 1'b0;
`ifdef ROUND_TIMER_EN
        timer_d      = timer_q;
`endif

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_INTRO;
                    wins1_d = '0;
                    wins2_d = '0;
                    round_d = RW'(1);
                end
            end
            ST_INTRO: begin
                if (tick) begin
                    if (pcnt_q <= PCW'(1)) begin
                        state_d = ST_FIGHT;
`ifdef ROUND_TIMER_EN
                        timer_d = TMW'(ROUND_TIME);
`endif
                    end else begin
                        pcnt_d = pcnt_q - PCW'(1);
                    end
                end
            end
            ST_FIGHT: begin
`ifdef ROUND_TIMER_EN
                if (tick && timer_q != '0) begin
                    timer_d = timer_q - TMW'(1);
                end
`endif
                if (ko_hit) begin
                    state_d      = ST_KO;
                    rwin_d       = ko_win;
                    round_done_d = 1'b1;
                    pcnt_d       = PCW'(KO_HOLD_TICKS);
                    if (ko_win == WIN_P1 && wins1_q < WW'(ROUNDS_TO_WIN)) begin
                        wins1_d = wins1_q + WW'(1);
                    end
                    if (ko_win == WIN_P2 && wins2_q < WW'(ROUNDS_TO_WIN)) begin
                        wins2_d = wins2_q + WW'(1);
                    end
                end
            end
            ST_KO: begin
                if (tick) begin
                    if (pcnt_q <= PCW'(1)) begin
                        if (wins1_q == WW'(ROUNDS_TO_WIN)) begin
                            state_d = ST_OVER;
                            mwin_d  = WIN_P1;
                        end else if (wins2_q == WW'(ROUNDS_TO_WIN)) begin
                            state_d = ST_OVER;
                            mwin_d  = WIN_P2;
                        end else if (round_q == RW'(MAX_ROUNDS)) begin
                            state_d = ST_OVER;
                            if (wins1_q > wins2_q) begin
                                mwin_d = WIN_P1;
                            end else if (wins2_q > wins1_q) begin
                                mwin_d = WIN_P2;
                            end else begin
                                mwin_d = WIN_DRAW;
                            end
                        end else begin
                            state_d = ST_INTRO;
                            round_d = round_q + RW'(1);
                        end
                    end else begin
                        pcnt_d = pcnt_q - PCW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every INTRO entry restarts the health block and clears the round result.
        enter_intro = (state_d == ST_INTRO) && (state_q != ST_INTRO);
        if (enter_intro) begin
            rwin_d = WIN_NONE;
            pcnt_d = PCW'(INTRO_TICKS);
        end
        if (state_d != ST_OVER) begin
            mwin_d = WIN_NONE;
        end

        hm_reset_d = (state_d == ST_IDLE) || enter_intro;
        fight_en_d = (state_d == ST_FIGHT);
        tick_cnt_d = (state_d != state_q || tick) ? '0 : tick_cnt_q + TCW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            pcnt_q       <= '0;
            round_q      <= '0;
            wins1_q      <= '0;
            wins2_q      <= '0;
            rwin_q       <= WIN_NONE;
            mwin_q       <= WIN_NONE;
            hm_reset_q   <= 1'b1;
            fight_en_q   <= 1'b0;
            round_done_q <= 1'b0;
`ifdef ROUND_TIMER_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            pcnt_q       <= pcnt_d;
            round_q      <= round_d;
            wins1_q      <= wins1_d;
            wins2_q      <= wins2_d;
            rwin_q       <= rwin_d;
            mwin_q       <= mwin_d;
            hm_reset_q   <= hm_reset_d;
            fight_en_q   <= fight_en_d;
            round_done_q <= round_done_d;
`ifdef ROUND_TIMER_EN
            timer_q      <= timer_d;
`endif
        end
    end

    assign phase        = state_q;
    assign round_num    = round_q;
    assign wins_1       = wins1_q;
    assign wins_2       = wins2_q;
    assign round_winner = rwin_q;
    assign match_winner = mwin_q;
    assign hm_reset     = hm_reset_q;
    assign fight_en     = fight_en_q;
    assign round_done   = round_done_q;

endmodule
